tt_vstore_packetizer: RTL and testbench
=======================================

TT_VSTORE_PACKETIZER -- requirements
Module: tt_vstore_packetizer

Interface
REQ-001 SHALL have parameter VLEN, default 256: vector register width in bits.
REQ-002 SHALL have parameter PKT_W, default 512: store packet width; integer multiple of VLEN.
REQ-003 SHALL have parameter BUF_DEPTH, default 8: uop slots buffered; power of two, at least PKT_W/VLEN.
REQ-004 SHALL have parameter STORE_CREDITS, default 4: initial downstream credits.
REQ-005 SHALL have ports i_clk in 1 clock; i_reset_n in 1 reset, synchronous, active-low.
REQ-006 SHALL have uop ports (all in): i_uop_fire 1, i_uop_first 1, i_uop_last 1, i_uop_is_store 1, i_uop_is_vsm 1, i_uop_is_vsr 1, i_uop_data_size 2, i_uop_vl clog2(VLEN+1), i_uop_nfield 3, i_store_data VLEN.
REQ-007 SHALL have i_store_credit in 1: one credit returned per cycle when high.
REQ-008 SHALL have i_flush in 1: abort the current store.
REQ-009 SHALL have outputs o_store_valid 1, o_store_data PKT_W, o_store_byte_en PKT_W/8, o_store_last 1, o_stall 1.

Function
REQ-010 SHALL implement the states IDLE, WAIT, SEND.
- IDLE to SEND: fire, store, first and last in the same cycle.
- IDLE to WAIT: fire, store and first, but not last.
- WAIT to SEND: fire and last.
- SEND to IDLE: the final packet is sent.
REQ-011 SHALL write i_store_data to buffer slot wptr on each fire with is_store; wptr increments, and resets to 0 on the last uop.
REQ-012 SHALL latch total store bytes (TB) on the first fire:
- vsr: (nfield+1)*VLEN/8, valid for nfield 0, 1, 3, 7 only.
- vsm: ceil(vl/8).
- Otherwise: vl<<data_size.
- vl==0 with non-vsr: TB=0.
REQ-013 SHALL compute packet count = ceil(TB/(PKT_W/8)); counter width SHALL hold BUF_DEPTH*VLEN/PKT_W without overflow.
REQ-014 SHALL go from SEND straight to IDLE on its first cycle when TB=0, emitting no packet.
REQ-015 SHALL assert o_store_valid = (state==SEND) && credits>0 && packets remaining>0; no ready handshake; the packet is consumed in the cycle valid is high.
REQ-016 SHALL drive o_store_data as the concatenation of slots rptr..rptr+PKT_W/VLEN-1, lowest slot in the LSBs; rptr advances by PKT_W/VLEN per packet and wraps modulo BUF_DEPTH.
REQ-017 SHALL assert o_store_last with the final packet of the store.
REQ-018 SHALL update credits as credits + i_store_credit - o_store_valid, including simultaneous return and send; credits SHALL never exceed STORE_CREDITS or go below 0.
REQ-019 SHALL assert o_stall combinationally whenever state==SEND.
REQ-020 SHALL, on i_flush, next cycle set state IDLE, wptr=rptr=0 and packets remaining=0, and preserve credits; flush SHALL take priority over a same-cycle fire.
REQ-021 SHALL ignore a fire with is_store=0 for all state, pointer and count updates.

Reset
REQ-022 SHALL reset to: state IDLE, wptr=rptr=0, packet count 0, credits=STORE_CREDITS.
REQ-023 SHALL drive at reset o_store_valid=0, o_store_last=0, o_stall=0, o_store_byte_en=0; buffer contents are not reset.
REQ-024 SHALL, on reset mid-SEND, drop remaining packets and emit no further valid.

Configuration
REQ-025 SHALL gate tail byte masking on macro TT_VSTORE_BYTE_MASK_EN.
- Defined: o_store_byte_en has ones for bytes below remaining bytes, i.e. min(TB - sent*PKT_W/8, PKT_W/8) low bits, and zero elsewhere.
- Undefined: o_store_byte_en is all ones whenever valid; the TB remainder logic is removed.
- In both cases byte_en SHALL be 0 when valid is low.

Structure
REQ-026 SHALL place the state enum typedef and the vsr nfield decode constants in the shared package tt_vpu_pkg.
REQ-027 SHALL contain one sub-module, tt_store_credit_ctr: a saturating up/down credit counter with parameter STORE_CREDITS.

Verification
REQ-028 Bench SHALL cover a single-uop e32 store, vl=8: TB=32 -> one packet, byte_en=0x...FFFFFFFF (32 ones), last=1, stall for 1 cycle.
REQ-029 Bench SHALL cover an 8-uop e64 store, vl=32, PKT_W=512: TB=256 -> 4 packets, rptr 0,2,4,6, last on the 4th.
REQ-030 Bench SHALL cover credits preset to 0 with 2 packets pending: valid stays low; credit pulse -> 1 packet; same-cycle credit return plus send -> credits unchanged.
REQ-031 Bench SHALL cover vl=0 unit-stride: no valid; back to IDLE one cycle after entering SEND.
REQ-032 Bench SHALL cover i_flush on the 2nd of 4 packets: next cycle state IDLE, valid=0, credits preserved, next store starts at slot 0.
REQ-033 Bench SHALL cover vsr nfield=3, VLEN=256: 2 packets, byte_en all ones with and without TT_VSTORE_BYTE_MASK_EN.

Source files
------------

// File: rtl/tt_vpu_pkg.sv
// Shared VPU types: store packetizer FSM states and vsr nfield codes.
// Used by tt_vstore_packetizer and its interface.
package tt_vpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
  } vst_state_e;

  localparam logic [2:0] NF_1REG = 3'd0;
  localparam logic [2:0] NF_2REG = 3'd1;
  localparam logic [2:0] NF_4REG = 3'd3;
  localparam logic [2:0] NF_8REG = 3'd7;

  // Unsupported nfield encodings yield zero registers (empty store).
  function automatic logic [3:0] vsr_nregs(
    input logic [2:0] nf
  );
    logic [3:0] n;
    n = 4'd0;
    unique case (nf)
      NF_1REG: n = 4'd1;
      NF_2REG: n = 4'd2;
      NF_4REG: n = 4'd4;
      NF_8REG: n = 4'd8;
      default: n = 4'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tt_vstore_packetizer_if.sv
// Uop-in / store-packet-out bundle of the vector store packetizer.
// master = uop issuer + store sink, slave = packetizer.
interface tt_vstore_packetizer_if #(
  parameter int VLEN  = 256,
  parameter int PKT_W = 512
);
  localparam int VLW = $clog2(VLEN + 1);

  logic               i_uop_fire;
  logic               i_uop_first;
  logic               i_uop_last;
  logic               i_uop_is_store;
  logic               i_uop_is_vsm;
  logic               i_uop_is_vsr;
  logic [1:0]         i_uop_data_size;
  logic [VLW-1:0]     i_uop_vl;
  logic [2:0]         i_uop_nfield;
  logic [VLEN-1:0]    i_store_data;
  logic               i_store_credit;
  logic               i_flush;
  logic               o_store_valid;
  logic [PKT_W-1:0]   o_store_data;
  logic [PKT_W/8-1:0] o_store_byte_en;
  logic               o_store_last;
  logic               o_stall;

  modport master (
    output i_uop_fire, i_uop_first, i_uop_last,
    output i_uop_is_store, i_uop_is_vsm, i_uop_is_vsr,
    output i_uop_data_size, i_uop_vl, i_uop_nfield,
    output i_store_data, i_store_credit, i_flush,
    input  o_store_valid, o_store_data,
    input  o_store_byte_en, o_store_last, o_stall
  );

  modport slave (
    input  i_uop_fire, i_uop_first, i_uop_last,
    input  i_uop_is_store, i_uop_is_vsm, i_uop_is_vsr,
    input  i_uop_data_size, i_uop_vl, i_uop_nfield,
    input  i_store_data, i_store_credit, i_flush,
    output o_store_valid, o_store_data,
    output o_store_byte_en, o_store_last, o_stall
  );

endinterface

// File: rtl/tt_store_credit_ctr.sv
// Saturating up/down counter of downstream store credits.
// Resets full; clamps at 0 and STORE_CREDITS.
module tt_store_credit_ctr #(
  parameter int STORE_CREDITS = 4
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_inc,
  input  logic i_dec,
  output logic [$clog2(STORE_CREDITS+1)-1:0] o_credits
);
  localparam int CW = $clog2(STORE_CREDITS + 1);
  localparam logic [CW-1:0] MAX = CW'(STORE_CREDITS);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cnt <= MAX;
    end else if (i_inc && !i_dec && r_cnt != MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (i_dec && !i_inc && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_credits = r_cnt;

endmodule

// File: rtl/tt_vstore_packetizer.sv
// Buffers vector store uops and emits credit-gated PKT_W store packets.
// Tail byte masking enabled by macro TT_VSTORE_BYTE_MASK_EN.
module tt_vstore_packetizer
  import tt_vpu_pkg::*;
#(
  parameter int VLEN          = 256,
  parameter int PKT_W         = 512,
  parameter int BUF_DEPTH     = 8,
  parameter int STORE_CREDITS = 4
) (
  input logic              i_clk,
  input logic              i_reset_n,
  tt_vstore_packetizer_if.slave io
);
  localparam int SPP   = PKT_W / VLEN;
  localparam int PB    = PKT_W / 8;
  localparam int PB_LG = $clog2(PB);
  localparam int PW    = $clog2(BUF_DEPTH);
  localparam int VLW   = $clog2(VLEN + 1);
  localparam int TBW   = VLW + 3;
  localparam int PCW   = $clog2(BUF_DEPTH * VLEN / PKT_W + 1);
  localparam int CW    = $clog2(STORE_CREDITS + 1);

  vst_state_e      r_state;
  vst_state_e      w_state_nx;
  logic [VLEN-1:0] r_buf [BUF_DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [PCW-1:0]  r_pkts;
  logic [CW-1:0]   w_credits;
  logic [TBW-1:0]  w_tb;
  logic [PCW-1:0]  w_pkts;
  logic            w_wr;
  logic            w_start;
  logic            w_valid;
  logic            w_last;
  logic            w_stall;
  logic            w_done;
  logic [PKT_W-1:0] w_data;
  logic [PB-1:0]   w_be;

  assign w_wr = io.i_uop_fire && io.i_uop_is_store
             && (r_state != ST_SEND);
  assign w_start = w_wr && io.i_uop_first
                && (r_state == ST_IDLE);

  // Total store bytes of the uop group, sampled on its first uop.
  always_comb begin
    w_tb = '0;
    if (io.i_uop_is_vsr) begin
      w_tb = TBW'(vsr_nregs(io.i_uop_nfield)) * TBW'(VLEN / 8);
    end else if (io.i_uop_is_vsm) begin
      w_tb = TBW'((io.i_uop_vl + VLW'(7)) >> 3);
    end else begin
      w_tb = TBW'(io.i_uop_vl) << io.i_uop_data_size;
    end
    w_pkts = PCW'((w_tb + TBW'(PB - 1)) >> PB_LG);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_valid    = 1'b0;
    w_last     = 1'b0;
    w_stall    = 1'b0;
    w_done     = 1'b0;
    if (r_state == ST_SEND) begin
      w_stall = 1'b1;
      w_valid = (w_credits != '0) && (r_pkts != '0);
      w_last  = w_valid && (r_pkts == PCW'(1));
      w_done  = (r_pkts == '0) || w_last;
    end
    unique case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nx = io.i_uop_last ? ST_SEND : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_wr && io.i_uop_last) w_state_nx = ST_SEND;
      end
      ST_SEND: begin
        if (w_done) w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
    if (io.i_flush) w_state_nx = ST_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (w_wr && !io.i_flush) begin
      r_buf[r_wptr] <= io.i_store_data;
    end
  end

  // Read pointer rewinds with the write pointer once a store completes.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n || io.i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_pkts <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= io.i_uop_last ? '0 : r_wptr + 1'b1;
      end
      if (w_start) begin
        r_pkts <= w_pkts;
      end else if (w_valid) begin
        r_pkts <= r_pkts - 1'b1;
      end
      if (w_done) begin
        r_rptr <= '0;
      end else if (w_valid) begin
        r_rptr <= r_rptr + PW'(SPP);
      end
    end
  end

  always_comb begin
    w_data = '0;
    for (int k = 0; k < SPP; k++) begin
      w_data[k*VLEN +: VLEN] = r_buf[r_rptr + PW'(k)];
    end
  end

`ifdef TT_VSTORE_BYTE_MASK_EN
  localparam logic [PB-1:0] BE_ONES = '1;
  logic [TBW-1:0] r_brem;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || io.i_flush) begin
      r_brem <= '0;
    end else if (w_start) begin
      r_brem <= w_tb;
    end else if (w_valid) begin
      r_brem <= (r_brem > TBW'(PB)) ? r_brem - TBW'(PB) : '0;
    end
  end

  always_comb begin
    w_be = '0;
    if (w_valid) begin
      w_be = BE_ONES;
      if (r_brem < TBW'(PB)) w_be = ~(BE_ONES << r_brem);
    end
  end
`else
  assign w_be = w_valid ? '1 : '0;
`endif

  tt_store_credit_ctr #(
    .STORE_CREDITS (STORE_CREDITS)
  ) u_cred (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_inc     (io.i_store_credit),
    .i_dec     (w_valid),
    .o_credits (w_credits)
  );

  assign io.o_store_valid   = w_valid;
  assign io.o_store_data    = w_data;
  assign io.o_store_byte_en = w_be;
  assign io.o_store_last    = w_last;
  assign io.o_stall         = w_stall;

endmodule

// File: tb/tb_tt_vstore_packetizer.sv
// Directed bench for tt_vstore_packetizer (VLEN=256, PKT_W=512).
// Expected byte enables follow TT_VSTORE_BYTE_MASK_EN when defined.
module tb_tt_vstore_packetizer;
  import tt_vpu_pkg::*;

`ifdef TT_VSTORE_BYTE_MASK_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif

  localparam logic [63:0] BE_ALL = '1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  tt_vstore_packetizer_if #(.VLEN(256), .PKT_W(512)) bus ();

  tt_vstore_packetizer #(
    .VLEN          (256),
    .PKT_W         (512),
    .BUF_DEPTH     (8),
    .STORE_CREDITS (4)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .io        (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [511:0] obs,
                     input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mk(input int s);
    logic [31:0] w;
    w = 32'h5A5A_0000 + 32'(s);
    return {8{w}};
  endfunction

  function automatic logic [511:0] pk(input int s);
    return {mk(s + 1), mk(s)};
  endfunction

  task automatic uop(input bit first, input bit last,
                     input bit vsm, input bit vsr,
                     input logic [1:0] ds, input logic [8:0] vl,
                     input logic [2:0] nf, input logic [255:0] d);
    bus.i_uop_fire      = 1'b1;
    bus.i_uop_is_store  = 1'b1;
    bus.i_uop_first     = first;
    bus.i_uop_last      = last;
    bus.i_uop_is_vsm    = vsm;
    bus.i_uop_is_vsr    = vsr;
    bus.i_uop_data_size = ds;
    bus.i_uop_vl        = vl;
    bus.i_uop_nfield    = nf;
    bus.i_store_data    = d;
    tick();
    bus.i_uop_fire      = 1'b0;
    bus.i_uop_first     = 1'b0;
    bus.i_uop_last      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_uop_fire      = 1'b0;
    bus.i_uop_first     = 1'b0;
    bus.i_uop_last      = 1'b0;
    bus.i_uop_is_store  = 1'b0;
    bus.i_uop_is_vsm    = 1'b0;
    bus.i_uop_is_vsr    = 1'b0;
    bus.i_uop_data_size = '0;
    bus.i_uop_vl        = '0;
    bus.i_uop_nfield    = '0;
    bus.i_store_data    = '0;
    bus.i_store_credit  = 1'b0;
    bus.i_flush         = 1'b0;

    // Reset state
    repeat (2) tick();
    rst_n = 1'b1;
    chk("rst_valid", bus.o_store_valid, 0);
    chk("rst_last", bus.o_store_last, 0);
    chk("rst_stall", bus.o_stall, 0);
    chk("rst_be", bus.o_store_byte_en, 0);
    chk("rst_cred", dut.w_credits, 4);
    chk("rst_state", dut.r_state, ST_IDLE);

    // Single uop e32 vl=8 -> 32 bytes, one packet
    uop(1, 1, 0, 0, 2'd2, 9'd8, 3'd0, mk(0));
    chk("s1_stall", bus.o_stall, 1);
    chk("s1_valid", bus.o_store_valid, 1);
    chk("s1_last", bus.o_store_last, 1);
    chk("s1_data", bus.o_store_data[255:0], mk(0));
    chk("s1_be", bus.o_store_byte_en,
        MASK ? 64'h0000_0000_FFFF_FFFF : BE_ALL);
    tick();
    chk("s1_stall_off", bus.o_stall, 0);
    chk("s1_valid_off", bus.o_store_valid, 0);
    chk("s1_be_off", bus.o_store_byte_en, 0);
    chk("s1_cred", dut.w_credits, 3);
    bus.i_store_credit = 1'b1;
    tick();
    bus.i_store_credit = 1'b0;
    chk("s1_cred_ret", dut.w_credits, 4);

    // 8 uops e64 vl=32 -> 256 bytes, four packets
    for (int i = 0; i < 8; i++) begin
      uop(i == 0, i == 7, 0, 0, 2'd3, 9'd32, 3'd0, mk(10 + i));
      if (i == 0) chk("m8_wait", dut.r_state, ST_WAIT);
    end
    for (int p = 0; p < 4; p++) begin
      chk("m8_valid", bus.o_store_valid, 1);
      chk("m8_rptr", dut.r_rptr, 2 * p);
      chk("m8_data", bus.o_store_data, pk(10 + 2 * p));
      chk("m8_last", bus.o_store_last, p == 3);
      chk("m8_be", bus.o_store_byte_en, BE_ALL);
      tick();
    end
    chk("m8_idle", dut.r_state, ST_IDLE);
    chk("m8_cred0", dut.w_credits, 0);

    // Zero credits with two packets pending
    for (int i = 0; i < 4; i++) begin
      uop(i == 0, i == 3, 0, 0, 2'd2, 9'd32, 3'd0, mk(20 + i));
    end
    chk("c0_stall", bus.o_stall, 1);
    chk("c0_hold0", bus.o_store_valid, 0);
    tick();
    chk("c0_hold1", bus.o_store_valid, 0);
    bus.i_store_credit = 1'b1;
    chk("c0_hold2", bus.o_store_valid, 0);
    tick();
    chk("c0_p1_valid", bus.o_store_valid, 1);
    chk("c0_p1_last", bus.o_store_last, 0);
    chk("c0_p1_data", bus.o_store_data, pk(20));
    chk("c0_p1_cred", dut.w_credits, 1);
    tick();
    bus.i_store_credit = 1'b0;
    chk("c0_same_cred", dut.w_credits, 1);
    chk("c0_p2_valid", bus.o_store_valid, 1);
    chk("c0_p2_last", bus.o_store_last, 1);
    chk("c0_p2_data", bus.o_store_data, pk(22));
    tick();
    chk("c0_end_cred", dut.w_credits, 0);
    chk("c0_end_valid", bus.o_store_valid, 0);
    bus.i_store_credit = 1'b1;
    repeat (5) tick();
    bus.i_store_credit = 1'b0;
    chk("c0_sat_cred", dut.w_credits, 4);

    // vl=0 unit stride: SEND for one cycle, no packet
    uop(1, 1, 0, 0, 2'd0, 9'd0, 3'd0, mk(30));
    chk("z_state", dut.r_state, ST_SEND);
    chk("z_stall", bus.o_stall, 1);
    chk("z_valid", bus.o_store_valid, 0);
    tick();
    chk("z_idle", dut.r_state, ST_IDLE);
    chk("z_stall_off", bus.o_stall, 0);
    chk("z_valid_off", bus.o_store_valid, 0);

    // Flush on the 2nd of 4 packets
    for (int i = 0; i < 8; i++) begin
      uop(i == 0, i == 7, 0, 0, 2'd3, 9'd32, 3'd0, mk(40 + i));
    end
    chk("f_p1_data", bus.o_store_data, pk(40));
    tick();
    bus.i_flush = 1'b1;
    chk("f_p2_valid", bus.o_store_valid, 1);
    chk("f_p2_data", bus.o_store_data, pk(42));
    tick();
    bus.i_flush = 1'b0;
    chk("f_idle", dut.r_state, ST_IDLE);
    chk("f_valid", bus.o_store_valid, 0);
    chk("f_cred", dut.w_credits, 2);
    chk("f_rptr", dut.r_rptr, 0);
    chk("f_wptr", dut.r_wptr, 0);
    bus.i_flush = 1'b1;
    uop(1, 1, 0, 0, 2'd2, 9'd8, 3'd0, mk(50));
    bus.i_flush = 1'b0;
    chk("f_prio_state", dut.r_state, ST_IDLE);
    chk("f_prio_valid", bus.o_store_valid, 0);
    uop(1, 1, 0, 0, 2'd2, 9'd8, 3'd0, mk(60));
    chk("f_next_valid", bus.o_store_valid, 1);
    chk("f_next_rptr", dut.r_rptr, 0);
    chk("f_next_data", bus.o_store_data[255:0], mk(60));
    tick();
    chk("f_next_cred", dut.w_credits, 1);
    bus.i_store_credit = 1'b1;
    repeat (3) tick();
    bus.i_store_credit = 1'b0;

    // vsr nfield=3 -> 128 bytes, two full packets
    for (int i = 0; i < 4; i++) begin
      uop(i == 0, i == 3, 0, 1, 2'd0, 9'd0, 3'd3, mk(70 + i));
    end
    chk("r_p1_valid", bus.o_store_valid, 1);
    chk("r_p1_data", bus.o_store_data, pk(70));
    chk("r_p1_be", bus.o_store_byte_en, BE_ALL);
    chk("r_p1_last", bus.o_store_last, 0);
    tick();
    chk("r_p2_data", bus.o_store_data, pk(72));
    chk("r_p2_be", bus.o_store_byte_en, BE_ALL);
    chk("r_p2_last", bus.o_store_last, 1);
    tick();
    chk("r_idle", dut.r_state, ST_IDLE);
    chk("r_cred", dut.w_credits, 2);

    // vsm vl=9 -> 2 bytes
    uop(1, 1, 1, 0, 2'd0, 9'd9, 3'd0, mk(75));
    chk("vm_valid", bus.o_store_valid, 1);
    chk("vm_last", bus.o_store_last, 1);
    chk("vm_be", bus.o_store_byte_en, MASK ? 64'h3 : BE_ALL);
    tick();
    chk("vm_cred", dut.w_credits, 1);
    bus.i_store_credit = 1'b1;
    repeat (3) tick();
    bus.i_store_credit = 1'b0;
    chk("vm_cred_ret", dut.w_credits, 4);

    // Reset in the middle of a two-packet store
    for (int i = 0; i < 4; i++) begin
      uop(i == 0, i == 3, 0, 1, 2'd0, 9'd0, 3'd3, mk(80 + i));
    end
    chk("rs_p1_valid", bus.o_store_valid, 1);
    tick();
    chk("rs_p2_valid", bus.o_store_valid, 1);
    rst_n = 1'b0;
    tick();
    chk("rs_valid", bus.o_store_valid, 0);
    chk("rs_state", dut.r_state, ST_IDLE);
    chk("rs_stall", bus.o_stall, 0);
    chk("rs_cred", dut.w_credits, 4);
    rst_n = 1'b1;
    tick();
    chk("rs_after", bus.o_store_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
